// File: rtl/enc_key_schedule_256_seq.sv
// -----------------------------------------------------------------------------
// enc_key_schedule_256_seq
//
// Sequential forward round-key generator for SWAN128 with a 256-bit master
// key. After a load, it emits one SIDE_SIZE-bit round key per accepted
// valid/ready handshake, for NUM_ROUNDS rounds. It then parks in DONE and
// exposes the final key/delta state. The decryption key schedule walks the
// same sequence backwards from that state.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   key_load     load request, accepted only in IDLE or DONE
//   key_in       master key (bit 0 of the key = MSB = key_in[KEY_SIZE-1])
//   busy         high while round keys are being produced (RUN)
//   sk_valid     round key available (RUN only)
//   sk_ready     consumer accepts sk this cycle
//   sk           current round key, 0 outside RUN
//   sk_round     index of the current round key, 0 outside RUN
//   done         high throughout DONE
//   final_key    key state after the last round, 0 outside DONE
//   final_delta  delta state after the last round, 0 outside DONE
// -----------------------------------------------------------------------------
module enc_key_schedule_256_seq #(
    parameter int                  KEY_SIZE   = 256,
    parameter int                  SIDE_SIZE  = 64,
    // Rotation distance; must satisfy 0 < PD < KEY_SIZE.
    parameter int                  PD         = 56,
    parameter logic [SIDE_SIZE-1:0] DELTA0    = 64'h9e3779b97f4a7c15,
    // Must be >= 1.
    parameter int                  NUM_ROUNDS = 64,
    // A single-round schedule still needs a 1-bit counter/port.
    localparam int                 RND_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_load,
    input  logic [KEY_SIZE-1:0]  key_in,
    output logic                 busy,
    output logic                 sk_valid,
    input  logic                 sk_ready,
    output logic [SIDE_SIZE-1:0] sk,
    output logic [RND_W-1:0]     sk_round,
    output logic                 done,
    output logic [KEY_SIZE-1:0]  final_key,
    output logic [SIDE_SIZE-1:0] final_delta
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_SIZE-1:0]  k_q;
    logic [SIDE_SIZE-1:0] d_q;
    logic [RND_W-1:0]     rnd_q;

    // Control decoded by the FSM, consumed by the datapath registers.
    logic load_en;
    logic step_en;
    logic last_round;

    // Combinational step results.
    logic [KEY_SIZE-1:0]  k_rot;
    logic [SIDE_SIZE-1:0] d_next;
    logic [SIDE_SIZE-1:0] sk_next;
    logic [KEY_SIZE-1:0]  k_next;

    assign last_round = (rnd_q == RND_W'(NUM_ROUNDS - 1));

    // -------------------------------------------------------------------------
    // Step function. With bit 0 as the MSB, "rotate right by PD" moves every
    // bit PD positions toward the LSB end, which is a plain right rotation of
    // the [KEY_SIZE-1:0] vector. The low SIDE_SIZE bits of the rotated key are
    // spec bits [KEY_SIZE-SIDE_SIZE : KEY_SIZE-1]. They become the round key
    // after the delta is added, and are written back in place. Because of
    // this write-back, the step is invertible from (k_next, d_next) alone.
    // -------------------------------------------------------------------------
    always_comb begin
        k_rot   = (k_q >> PD) | (k_q << (KEY_SIZE - PD));
        d_next  = d_q + DELTA0;
        sk_next = k_rot[SIDE_SIZE-1:0] + d_next;
        k_next  = {k_rot[KEY_SIZE-1:SIDE_SIZE], sk_next};
    end

    // -------------------------------------------------------------------------
    // FSM state register.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and outputs.
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        step_en  = 1'b0;
        busy     = 1'b0;
        sk_valid = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    load_en = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy     = 1'b1;
                sk_valid = 1'b1;
                // key_load is deliberately not looked at here: a sequence
                // cannot be restarted once it is under way.
                if (sk_ready) begin
                    step_en = 1'b1;
                    if (last_round) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (key_load) begin
                    load_en = 1'b1;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Key / delta / round-counter registers. These are plain registers, not
    // memories, so all of them take the synchronous reset. rst takes priority
    // over a load or a pending handshake in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            d_q   <= '0;
            rnd_q <= '0;
        end else if (load_en) begin
            k_q   <= key_in;
            d_q   <= '0;
            rnd_q <= '0;
        end else if (step_en) begin
            k_q   <= k_next;
            d_q   <= d_next;
            // The counter returns to 0 on the final handshake instead of
            // wrapping, so sk_round never shows an out-of-range index.
            rnd_q <= last_round ? '0 : rnd_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output gating. Round-key outputs are meaningful only in RUN, and final
    // state only in DONE. Outside those states they read 0, so a downstream
    // block never latches stale values.
    // -------------------------------------------------------------------------
    always_comb begin
        sk          = '0;
        sk_round    = '0;
        final_key   = '0;
        final_delta = '0;
        if (state_q == ST_RUN) begin
            sk       = sk_next;
            sk_round = rnd_q;
        end
        if (state_q == ST_DONE) begin
            final_key   = k_q;
            final_delta = d_q;
        end
    end

endmodule
